// File: rtl/bounce_gen.sv
`default_nettype none
// ============================================================================
//  Module   : bounce_gen
//  Purpose  : Contact-bounce emulator. On request, drives d_o to a new level
//             through cnt_n pulse/pause pairs (pulse = target level, pause =
//             reverted level), then holds the target for a settle period.
//  Revision : 1.0 - initial release
//
//  Build option:
//    BOUNCE_GEN_RANDOM_EN  defined   -> 16-bit Galois LFSR (taps 0xB400)
//                                       randomizes pulse/pause lengths as
//                                       min + (lfsr & msk), saturated, >= 1.
//                          undefined -> lengths are max(min,1); masks and
//                                       SEED are not used.
//
//  Ports:
//    clk, rst            clock, synchronous active-high reset
//    ena                 0 freezes state, counters, LFSR and d_o
//    req, val, cnt_n     start request, target level, bounce pair count
//    pulse_min/msk       pulse length base / random mask
//    pause_min/msk       pause length base / random mask
//    settle_len          final hold length (0 treated as 1)
//    d_o                 bouncing output
//    busy                sequence in progress
//    done                one-cycle completion strobe
// ============================================================================
module bounce_gen #(
    parameter int          CW   = 16,
    parameter int          NW   = 8,
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ena,
    input  logic          req,
    input  logic          val,
    input  logic [NW-1:0] cnt_n,
    input  logic [CW-1:0] pulse_min,
    input  logic [CW-1:0] pulse_msk,
    input  logic [CW-1:0] pause_min,
    input  logic [CW-1:0] pause_msk,
    input  logic [CW-1:0] settle_len,
    output logic          d_o,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PULSE  = 2'd1,
        S_PAUSE  = 2'd2,
        S_SETTLE = 2'd3
    } state_t;

    localparam logic [CW-1:0] c_one  = CW'(1);
    localparam logic [NW-1:0] c_bone = NW'(1);

    state_t        r_state;
    logic          r_val;
    logic [NW-1:0] r_cnt_n;
    logic [NW-1:0] r_bcnt;
    logic [CW-1:0] r_pmin;
    logic [CW-1:0] r_qmin;
    logic [CW-1:0] r_settle;
    logic [CW-1:0] r_dcnt;

    logic [CW-1:0] w_dp_new;   // first pulse length, from live inputs at req
    logic [CW-1:0] w_dp;       // pulse length from captured inputs
    logic [CW-1:0] w_dq;       // pause length from captured inputs
    logic [CW-1:0] w_ds_new;   // settle length from live inputs (cnt_n = 0)
    logic [CW-1:0] w_ds;       // settle length from captured inputs
    logic [NW-1:0] w_bcnt_inc;

    function automatic logic [CW-1:0] f_max1(input logic [CW-1:0] x);
        return (x == '0) ? c_one : x;
    endfunction

`ifdef BOUNCE_GEN_RANDOM_EN
    logic [15:0]   r_lfsr;
    logic [15:0]   w_lfsr_next;
    logic [CW-1:0] w_rnd;
    logic [CW-1:0] r_pmsk;
    logic [CW-1:0] r_qmsk;

    // Sum is one bit wider so an overflow can be detected and saturated.
    function automatic logic [CW-1:0] f_dur(input logic [CW-1:0] base,
                                           input logic [CW-1:0] msk,
                                           input logic [CW-1:0] rnd);
        logic [CW:0] s;
        s = {1'b0, base} + {1'b0, rnd & msk};
        if (s[CW])
            return '1;
        else
            return f_max1(s[CW-1:0]);
    endfunction

    assign w_lfsr_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ 16'hB400) : (r_lfsr >> 1);
    assign w_rnd       = r_lfsr[CW-1:0];
    assign w_dp_new    = f_dur(pulse_min, pulse_msk, w_rnd);
    assign w_dp        = f_dur(r_pmin, r_pmsk, w_rnd);
    assign w_dq        = f_dur(r_qmin, r_qmsk, w_rnd);
`else
    // Deterministic build: masks and seed have no function.
    logic w_unused;
    assign w_unused = ^{pulse_msk, pause_msk, SEED};

    assign w_dp_new = f_max1(pulse_min);
    assign w_dp     = f_max1(r_pmin);
    assign w_dq     = f_max1(r_qmin);
`endif

    assign w_ds_new   = f_max1(settle_len);
    assign w_ds       = f_max1(r_settle);
    assign w_bcnt_inc = r_bcnt + c_bone;

    // Each phase loads D-1 on entry and ends when the counter reads zero,
    // so a phase occupies exactly D cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            d_o      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            r_val    <= 1'b0;
            r_cnt_n  <= '0;
            r_bcnt   <= '0;
            r_pmin   <= '0;
            r_qmin   <= '0;
            r_settle <= '0;
            r_dcnt   <= '0;
`ifdef BOUNCE_GEN_RANDOM_EN
            r_lfsr   <= SEED;
            r_pmsk   <= '0;
            r_qmsk   <= '0;
`endif
        end else begin
            // done is a strobe: it never survives more than one cycle,
            // even if ena drops in the cycle it is shown.
            done <= 1'b0;
            if (ena) begin
`ifdef BOUNCE_GEN_RANDOM_EN
                r_lfsr <= w_lfsr_next;
`endif
                case (r_state)
                    S_IDLE: begin
                        if (req) begin
                            r_val    <= val;
                            r_cnt_n  <= cnt_n;
                            r_pmin   <= pulse_min;
                            r_qmin   <= pause_min;
                            r_settle <= settle_len;
`ifdef BOUNCE_GEN_RANDOM_EN
                            r_pmsk   <= pulse_msk;
                            r_qmsk   <= pause_msk;
`endif
                            r_bcnt   <= '0;
                            busy     <= 1'b1;
                            d_o      <= val;
                            if (cnt_n != '0) begin
                                r_state <= S_PULSE;
                                r_dcnt  <= w_dp_new - c_one;
                            end else begin
                                r_state <= S_SETTLE;
                                r_dcnt  <= w_ds_new - c_one;
                            end
                        end
                    end
                    S_PULSE: begin
                        if (r_dcnt == '0) begin
                            r_state <= S_PAUSE;
                            d_o     <= ~r_val;
                            r_dcnt  <= w_dq - c_one;
                        end else begin
                            r_dcnt  <= r_dcnt - c_one;
                        end
                    end
                    S_PAUSE: begin
                        if (r_dcnt == '0) begin
                            // Counter never exceeds cnt_n-1 here, so the
                            // increment cannot wrap even for cnt_n = all ones.
                            r_bcnt <= w_bcnt_inc;
                            d_o    <= r_val;
                            if (w_bcnt_inc == r_cnt_n) begin
                                r_state <= S_SETTLE;
                                r_dcnt  <= w_ds - c_one;
                            end else begin
                                r_state <= S_PULSE;
                                r_dcnt  <= w_dp - c_one;
                            end
                        end else begin
                            r_dcnt <= r_dcnt - c_one;
                        end
                    end
                    S_SETTLE: begin
                        if (r_dcnt == '0) begin
                            r_state <= S_IDLE;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                        end else begin
                            r_dcnt  <= r_dcnt - c_one;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bounce_gen.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bounce_gen
//  Purpose  : Self-checking bench for bounce_gen. A waveform model expands
//             each accepted request into the full list of expected output
//             cycles; a compare process checks every cycle against it, and
//             directed scenarios add hand-computed expectations.
//  Revision : 1.0 - initial release
//  Honours BOUNCE_GEN_RANDOM_EN the same way as the design.
// ============================================================================
module tb_bounce_gen;

`ifdef BOUNCE_GEN_RANDOM_EN
    localparam bit c_RAND = 1'b1;
`else
    localparam bit c_RAND = 1'b0;
`endif
    localparam logic [15:0] c_SEED = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ena = 1'b1;
    logic        req = 1'b0;
    logic        val = 1'b0;
    logic [7:0]  cnt_n = 8'd0;
    logic [15:0] pulse_min = 16'd5;
    logic [15:0] pulse_msk = 16'h001F;
    logic [15:0] pause_min = 16'd20;
    logic [15:0] pause_msk = 16'h00FF;
    logic [15:0] settle_len = 16'd100;
    logic        d_o, busy, done;

    int n_checks = 0;
    int n_fail   = 0;
    int n_prn    = 0;

    bounce_gen #(.CW(16), .NW(8), .SEED(c_SEED)) dut (
        .clk(clk), .rst(rst), .ena(ena), .req(req), .val(val), .cnt_n(cnt_n),
        .pulse_min(pulse_min), .pulse_msk(pulse_msk),
        .pause_min(pause_min), .pause_msk(pause_msk),
        .settle_len(settle_len), .d_o(d_o), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // ---------------- waveform model ----------------
    logic [2:0]  q[$];          // {d_o, busy, done} per future active cycle
    logic        e_d = 1'b0, e_b = 1'b0, e_dn = 1'b0;
    logic [15:0] m_lfsr = c_SEED;
    bit          m_valid = 1'b0;

    function automatic logic [15:0] m_step(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    endfunction

    function automatic int m_dur(input int base, input int msk, input logic [15:0] l);
        int s;
        s = base + (c_RAND ? (int'(l) & msk) : 0);
        if (s > 65535) s = 65535;
        if (s == 0) s = 1;
        return s;
    endfunction

    task automatic m_build();
        logic [15:0] lv;
        int d;
        lv = m_lfsr;
        for (int i = 0; i < int'(cnt_n); i++) begin
            d = m_dur(int'(pulse_min), int'(pulse_msk), lv);
            repeat (d) begin q.push_back({val, 1'b1, 1'b0}); lv = m_step(lv); end
            d = m_dur(int'(pause_min), int'(pause_msk), lv);
            repeat (d) begin q.push_back({~val, 1'b1, 1'b0}); lv = m_step(lv); end
        end
        d = (settle_len == 16'd0) ? 1 : int'(settle_len);
        repeat (d) q.push_back({val, 1'b1, 1'b0});
        q.push_back({val, 1'b0, 1'b1});
    endtask

    always @(posedge clk) begin
        logic [2:0] ent;
        if (rst) begin
            q.delete();
            e_d = 1'b0; e_b = 1'b0; e_dn = 1'b0;
            m_lfsr = c_SEED;
            m_valid = 1'b1;
        end else if (m_valid) begin
            e_dn = 1'b0;
            if (ena) begin
                if (q.size() == 0 && req) m_build();
                if (q.size() > 0) begin
                    ent = q.pop_front();
                    {e_d, e_b, e_dn} = ent;
                end else begin
                    e_b = 1'b0;
                end
                m_lfsr = m_step(m_lfsr);
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            n_checks++;
            if ({d_o, busy, done} !== {e_d, e_b, e_dn}) begin
                n_fail++;
                if (n_prn < 20)
                    $display("FAIL model_cmp t=%0t d_o/busy/done actual=%b%b%b required=%b%b%b",
                             $time, d_o, busy, done, e_d, e_b, e_dn);
                n_prn++;
            end
        end
    end

    // ---------------- directed stimulus ----------------
    logic dh [0:255];
    int   busy_cnt, done_at;
    int   p_cnt, p_min, p_max, q_cnt, q_min, q_max;
    logic cap_val;

    task automatic chk(input string nm, input int act, input int req_v);
        n_checks++;
        if (act !== req_v) begin
            n_fail++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, req_v);
        end
    endtask

    task automatic idle(input int k);
        repeat (k) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge showing cycle k+1.
    task automatic start(input logic v, input int n, input int settle);
        req = 1'b1; val = v; cnt_n = 8'(n); settle_len = 16'(settle);
        pulse_min = 16'd5; pause_min = 16'd20;
        cap_val = v;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic classify(input logic lvl, input int rl);
        if (lvl == cap_val) begin
            p_cnt++; if (rl < p_min) p_min = rl; if (rl > p_max) p_max = rl;
        end else begin
            q_cnt++; if (rl < q_min) q_min = rl; if (rl > q_max) q_max = rl;
        end
    endtask

    // Observes a sequence from offset 1; returns at the done cycle, or one
    // cycle after a reset planted at offset rst_at.
    task automatic run(input int req_at, input int ena_at, input int ena_len, input int rst_at);
        logic lvl;
        int   rl;
        busy_cnt = 0; done_at = 0;
        p_cnt = 0; q_cnt = 0; p_min = 1 << 30; q_min = 1 << 30; p_max = 0; q_max = 0;
        lvl = d_o; rl = 0;
        for (int n = 1; n <= 60000; n++) begin
            if (n < 256) dh[n] = d_o;
            if (busy) begin
                busy_cnt++;
                if (d_o == lvl) rl++;
                else begin classify(lvl, rl); lvl = d_o; rl = 1; end
            end
            if (done) begin done_at = n; ena = 1'b1; req = 1'b0; return; end
            if (n == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                done_at = -1;
                return;
            end
            req = (n == req_at);
            if (req) begin val = ~cap_val; cnt_n = 8'd0; pulse_min = 16'd9; end
            ena = !(n >= ena_at && n < ena_at + ena_len);
            @(negedge clk);
        end
        ena = 1'b1; req = 1'b0;
        chk("run_timeout", 0, 1);
    endtask

    initial begin
        rst = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_d_o", int'(d_o), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        idle(6);
        chk("idle_busy", int'(busy), 0);
        chk("idle_d_o", int'(d_o), 0);

        // A: val=1, 3 bounces, 5/20 lengths, settle 100
        start(1'b1, 3, 100);
        chk("A_first_level", int'(d_o), 1);
        chk("A_first_busy", int'(busy), 1);
        run(0, 0, 0, 0);
        chk("A_completed", int'(done_at > 0), 1);
        chk("A_hold_level", int'(d_o), 1);
`ifndef BOUNCE_GEN_RANDOM_EN
        chk("A_busy_len", busy_cnt, 175);
        chk("A_done_at", done_at, 176);
        chk("A_d5", int'(dh[5]), 1);
        chk("A_d6", int'(dh[6]), 0);
        chk("A_d25", int'(dh[25]), 0);
        chk("A_d26", int'(dh[26]), 1);
        chk("A_d31", int'(dh[31]), 0);
        chk("A_d75", int'(dh[75]), 0);
        chk("A_d76", int'(dh[76]), 1);
`endif
        idle(3);
        chk("A_after_d_o", int'(d_o), 1);

        // B: clean edge, cnt_n=0 settle_len=0, then back-to-back request
        start(1'b0, 0, 0);
        chk("B_edge_k1", int'(d_o), 0);
        run(0, 0, 0, 0);
        chk("B_busy_len", busy_cnt, 1);
        chk("B_done_at", done_at, 2);
        start(1'b1, 0, 3);
        chk("B2B_busy", int'(busy), 1);
        chk("B2B_d_o", int'(d_o), 1);
        run(0, 0, 0, 0);
        chk("B2B_busy_len", busy_cnt, 3);
        chk("B2B_done_at", done_at, 4);
        idle(3);

        // C: request while busy ignored, ena low 50 cycles inside a pause
        start(1'b0, 3, 100);
        run(3, 10, 50, 0);
        chk("C_completed", int'(done_at > 0), 1);
        chk("C_final_level", int'(d_o), 0);
`ifndef BOUNCE_GEN_RANDOM_EN
        chk("C_busy_len", busy_cnt, 225);
        chk("C_done_at", done_at, 226);
`endif
        idle(3);

        // D: reset mid-pulse, then replay from the same post-reset offset
        do_reset();
        idle(2);
        start(1'b1, 2, 10);
        run(0, 0, 0, 3);
        chk("D_rst_d_o", int'(d_o), 0);
        chk("D_rst_busy", int'(busy), 0);
        chk("D_rst_done", int'(done), 0);
        idle(5);
        chk("D_no_done", int'(done), 0);
        do_reset();
        idle(2);
        start(1'b1, 2, 10);
        run(0, 0, 0, 0);
        chk("D_replay_completed", int'(done_at > 0), 1);
`ifndef BOUNCE_GEN_RANDOM_EN
        chk("D_replay_busy_len", busy_cnt, 60);
`endif
        idle(3);

        // E: 80 bounces toward 0 from d_o=1; length ranges
        start(1'b0, 80, 10);
        run(0, 0, 0, 0);
        chk("E_completed", int'(done_at > 0), 1);
        chk("E_pulse_count", p_cnt, 80);
        chk("E_pause_count", q_cnt, 80);
        chk("E_pulse_ge5", int'(p_min >= 5), 1);
        chk("E_pulse_le36", int'(p_max <= 36), 1);
        chk("E_pause_ge20", int'(q_min >= 20), 1);
        chk("E_pause_le275", int'(q_max <= 275), 1);
        chk("E_final_level", int'(d_o), 0);
        idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/bounce_gen.md
# bounce_gen

Synthesizable contact-bounce emulator: on request it drives a 1-bit output to a new level through a programmable burst of short glitch pulses and longer reverting pauses, then holds the target level. It is the stimulus end of the debounce path. It feeds `debounce` inputs in hardware-in-loop self-test, and it replaces behavioural bounce tasks in benches. Pulse and pause lengths are randomized by an internal LFSR within software-set ranges.

## Interface
- `CW`, 16: duration counter width, 1..16.
- `NW`, 8: bounce-count width.
- `SEED`, 16'hACE1: LFSR reset value; must be nonzero.

- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high
- `ena`  in  1  enable; 0 freezes FSM, counters and LFSR
- `req`  in  1  start request, sampled only in IDLE
- `val`  in  1  target level, captured with `req`
- `cnt_n`  in  NW  number of pulse/pause pairs, captured with `req`
- `pulse_min`, `pulse_msk`  in  CW each  pulse length base and random mask
- `pause_min`, `pause_msk`  in  CW each  pause length base and random mask
- `settle_len`  in  CW  final stable-hold length
- `d_o`  out  1  bouncing output
- `busy`  out  1  sequence in progress
- `done`  out  1  one-cycle completion strobe

## Operation
- FSM states: IDLE, PULSE, PAUSE, SETTLE.
- IDLE
  - Entered on `req`=1 with `ena`=1. Captures `val`, `cnt_n`, and all length inputs.
  - If `cnt_n`>0, goes to PULSE. If `cnt_n`=0, goes straight to SETTLE, giving a clean edge.
- PULSE
  - `d_o`=val for Dp cycles, then goes to PAUSE.
- PAUSE
  - `d_o`=~val for Dq cycles.
  - Bounce counter increments. If the counter equals `cnt_n`, goes to SETTLE; otherwise goes to PULSE.
- SETTLE
  - `d_o`=val for Ds = max(`settle_len`,1) cycles.
  - Then returns to IDLE with `done`=1 for one cycle. `d_o` keeps val.
- Duration rule: Dp = `pulse_min` + (lfsr[CW-1:0] & `pulse_msk`). Dq is computed the same way from the pause inputs.
  - Use a CW+1-bit sum. Saturate to 2^CW-1. A result of 0 is forced to 1.
  - Computed when each phase is entered, from the LFSR value of that cycle.
- Duration counter: loaded with D-1 and decrements. The phase ends at 0, so each phase lasts exactly D cycles.
- LFSR: 16-bit Galois, taps 0xB400. Advances every cycle with `ena`=1, including in IDLE.
- `req` while `busy` is ignored; no queueing. Captured values are not affected by later input changes.
- `ena`=0 mid-sequence: state, counters, LFSR and `d_o` hold. The sequence resumes when `ena` returns to 1.
- `rst` mid-sequence: immediate return to reset values and IDLE. No `done`.

## Timing
- Reset values: `d_o`=0, `busy`=0, `done`=0, state IDLE, LFSR=`SEED`, counters 0.
- `req` sampled at edge k:
  - `busy`=1 and first phase level on `d_o` from cycle k+1.
  - All outputs are registered.
- Total busy length = Σ(Dp+Dq) + Ds cycles.
- Final SETTLE cycle is followed by a cycle with `busy`=0, `done`=1.
- `req` in the same cycle as `done`: accepted. This allows back-to-back sequences with zero IDLE gap.
- Bounce counter is NW bits wide. `cnt_n`=2^NW-1 is legal and does not wrap.

## Configuration
- `BOUNCE_GEN_RANDOM_EN` defined: LFSR built; durations randomized as above.
- Not defined:
  - No LFSR; masks are ignored.
  - Dp = max(`pulse_min`,1), Dq = max(`pause_min`,1), giving deterministic periodic bounce.
  - `SEED` unused.

## Test plan
- Reset held 4 cycles, then released → `d_o`=0, `busy`=0, `done`=0; nothing changes without `req`.
- Deterministic build, val=1, cnt_n=3, pulse_min=5, pause_min=20, settle_len=100 → `d_o` pattern 5×1, 20×0 (three times), then 100×1. `busy` lasts 175 cycles. `done` fires at cycle 176 after `req`. `d_o` stays 1.
- Random build, masks 0x1F/0xFF, 80 bounces, val=0 from `d_o`=1 → every pulse is 5..36 cycles and every pause 20..275 cycles. A reference LFSR model matches the sequence cycle-exactly.
- cnt_n=0, settle_len=0 → `d_o` changes at k+1, `busy` lasts 1 cycle, then `done`.
- `req` pulsed while busy, plus `ena` low for 50 cycles mid-PAUSE → extra request ignored; output frozen for 50 cycles; total sequence lengthened by exactly 50.
- `rst` asserted mid-PULSE with val=1 → next cycle `d_o`=0, `busy`=0, no `done`. New `req` after reset replays the same random sequence as the first run.
